assoc_data_cache: RTL
=====================

ASSOC_DATA_CACHE -- requirements
Module: assoc_data_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 4, number of sets; power of 2, at least 2.
REQ-002 SHALL have parameter WAYS, default 2, associativity; 1 or 2 only.
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line; power of 2, at least 2.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cpu_read_en  in  1  load request.
REQ-007 SHALL have port cpu_write_en  in  1  store request.
REQ-008 SHALL have port cpu_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port cpu_wdata  in  32  store data, lane-aligned.
REQ-010 SHALL have port cpu_byte_en  in  4  store byte enables.
REQ-011 SHALL have port flush  in  1  invalidate all lines.
REQ-012 SHALL have port cpu_rdata  out  32  load data.
REQ-013 SHALL have port cpu_stall  out  1  hold pipeline.
REQ-014 SHALL have ports mem_req, mem_we (out 1), mem_addr, mem_wdata (out 32), mem_byte_en (out 4): memory command.
REQ-015 SHALL have ports mem_rdata (in 32), mem_ready (in 1): memory accepts the command, and for reads returns data, in the cycle mem_ready=1.
REQ-016 SHALL have ports hit_cnt, miss_cnt  out  32  load hit/miss counters.

Function
REQ-017 SHALL split the address as offset [log2(LINE_WORDS)+1:2], index next log2(NUM_SETS) bits, tag the remainder.
REQ-018 SHALL use FSM states IDLE, REFILL, WRITE; flush completes in one IDLE cycle.
REQ-019 SHALL serve a load hit in IDLE combinationally: cpu_rdata = hit word, cpu_stall=0, hit_cnt+1.
REQ-020 SHALL, on a load miss in IDLE, assert cpu_stall, increment miss_cnt, select the victim way (lowest invalid way, else LRU way), and go to REFILL.
REQ-021 SHALL, in REFILL, hold mem_req=1, mem_we=0, mem_addr=line_base+4*k, with k advancing 0..LINE_WORDS-1 on each mem_ready; word k is captured on that edge.
REQ-022 SHALL, on mem_ready for k=LINE_WORDS-1, write data/tag/valid into the victim way, update LRU, and return to IDLE; the replayed load then hits with no further stall.
REQ-023 SHALL handle any store as write-through, no-allocate: on hit, merge enabled bytes into the cached word on the IDLE edge; on hit or miss, go to WRITE.
REQ-024 SHALL, in WRITE, drive mem_req=1, mem_we=1 with the latched address, data and byte enables until mem_ready; cpu_stall=1 except in the mem_ready cycle; then return to IDLE.
REQ-025 SHALL, per set, hold one LRU bit (WAYS=2) pointing to the way not used by the latest load hit, store hit or refill; with WAYS=1 the bit is unused.
REQ-026 SHALL, when flush=1 in IDLE, clear all valid bits and LRU bits, assert cpu_stall for that cycle, and ignore the CPU request; flush outside IDLE is held off until IDLE.
REQ-027 SHALL give cpu_read_en priority when cpu_read_en and cpu_write_en are both 1 (the write is ignored).
REQ-028 SHALL drive mem_req=0 and all mem_* outputs to 0 in IDLE.
REQ-029 SHALL wrap hit_cnt and miss_cnt modulo 2^32; a replayed load after refill counts as a hit.
REQ-030 SHALL give cpu_rdata=0 when not a load hit.

Reset
REQ-031 SHALL, on reset_n=0, immediately clear state to IDLE, clear all valid and LRU bits, the refill counter, hit_cnt and miss_cnt, and force cpu_stall=0 and mem_* outputs to 0.
REQ-032 SHALL abort any in-flight REFILL or WRITE on reset with no line installed; data array contents are not reset.

Structure
REQ-033 SHALL place the FSM state type, the byte-merge function and the address-split width constants in shared package cache_pkg.
REQ-034 SHALL instantiate sub-module cache_way (tag, valid and data storage for one way, with a read port and a write port) WAYS times.

Verification
REQ-035 SHALL test: after reset, load 0x100 -> 4 reads 0x100..0x10C, stall for 4 mem_ready cycles, replay hits, miss_cnt=1, hit_cnt=1.
REQ-036 SHALL test, with WAYS=2 and NUM_SETS=4: fill 0x000 and 0x040 (same set), hit 0x000, load 0x080 -> way holding 0x040 replaced; 0x000 still hits.
REQ-037 SHALL test: store hit 0x104, data 0xAABBCCDD, byte_en 0b0011 -> cached word low half = 0xCCDD, one write with mem_byte_en=0011, stall released in the mem_ready cycle.
REQ-038 SHALL test: store miss 0x200 -> one memory write, no refill; a later load 0x200 misses.
REQ-039 SHALL test: flush asserted together with load 0x100 (hit) -> one stall cycle; the next load 0x100 misses.
REQ-040 SHALL test: reset_n pulse during REFILL at k=2 -> mem_req=0 immediately; a later load of the same line misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared FSM state type, address-split widths and byte-merge helper for the
// associative data cache.
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} cache_state_e;

  function automatic int unsigned tag_width(input int unsigned num_sets,
                                            input int unsigned line_words);
    return ADDR_W - BYTE_OFF_W - $clog2(num_sets) - $clog2(line_words);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byte_en);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid bits, tags and line data, with a combinational read
// port and a write port that either installs a whole line or updates a word.
module cache_way #(
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned OFF_W      = 2,
  parameter int unsigned TAG_W      = 26
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [IDX_W-1:0]             rd_index,
  input  logic [OFF_W-1:0]             rd_offset,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [31:0]                  rd_word,
  input  logic                         clear_all,
  input  logic                         word_we,
  input  logic                         fill_we,
  input  logic [IDX_W-1:0]             wr_index,
  input  logic [OFF_W-1:0]             wr_offset,
  input  logic [31:0]                  wr_word,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [LINE_WORDS-1:0][31:0]  wr_line
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage are deliberately not reset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[wr_index] <= wr_tag;
      for (int w = 0; w < LINE_WORDS; w++) data_q[wr_index][w] <= wr_line[w];
    end else if (word_we) begin
      data_q[wr_index][wr_offset] <= wr_word;
    end
  end

endmodule

// File: rtl/assoc_data_cache.sv
// Write-through, no-allocate, 1- or 2-way set-associative data cache with
// blocking line refill and per-set LRU replacement.
module assoc_data_cache
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_en,
  input  logic        flush,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = tag_width(NUM_SETS, LINE_WORDS);
  localparam int unsigned LINE_LSB = BYTE_OFF_W + OFF_W;

  cache_state_e                    state_q;
  logic [OFF_W-1:0]                refill_cnt_q;
  logic                            victim_q;
  logic [ADDR_W-1:BYTE_OFF_W]      addr_q;
  logic [31:0]                     wdata_q;
  logic [3:0]                      be_q;
  logic [NUM_SETS-1:0]             lru_q;
  logic [31:0]                     hit_cnt_q, miss_cnt_q;
  logic [LINE_WORDS-1:0][31:0]     line_buf_q, fill_line;

  logic [OFF_W-1:0] cpu_offset;
  logic [IDX_W-1:0] cpu_index, refill_index, wr_index;
  logic [TAG_W-1:0] cpu_tag;
  logic             unused_addr_lsbs;

  assign cpu_offset       = cpu_addr[BYTE_OFF_W +: OFF_W];
  assign cpu_index        = cpu_addr[LINE_LSB +: IDX_W];
  assign cpu_tag          = cpu_addr[ADDR_W-1 -: TAG_W];
  assign refill_index     = addr_q[LINE_LSB +: IDX_W];
  assign unused_addr_lsbs = ^cpu_addr[BYTE_OFF_W-1:0];

  logic [WAYS-1:0]  way_valid, hit_vec, word_we, fill_we;
  logic [TAG_W-1:0] way_tag  [WAYS];
  logic [31:0]      way_word [WAYS];
  logic             hit, hit_way, victim_sel;
  logic [31:0]      hit_word;
  logic             idle, do_flush, do_load, do_store, load_hit, load_miss, store_hit;
  logic             refill_last;

  always_comb begin
    hit_word   = '0;
    hit_way    = 1'b0;
    victim_sel = (WAYS == 2) ? lru_q[cpu_index] : 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = way_valid[w] && (way_tag[w] == cpu_tag);
      if (hit_vec[w]) begin
        hit_word = way_word[w];
        hit_way  = 1'(w);
      end
    end
    // Lowest invalid way wins over the LRU pointer.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_sel = 1'(w);
    end
  end

  assign hit         = |hit_vec;
  assign idle        = (state_q == StIdle);
  assign do_flush    = idle && flush;
  assign do_load     = idle && !flush && cpu_read_en;
  assign do_store    = idle && !flush && !cpu_read_en && cpu_write_en;
  assign load_hit    = do_load && hit;
  assign load_miss   = do_load && !hit;
  assign store_hit   = do_store && hit;
  assign refill_last = (state_q == StRefill) && mem_ready &&
                       (refill_cnt_q == OFF_W'(LINE_WORDS - 1));
  assign wr_index    = (state_q == StRefill) ? refill_index : cpu_index;

  always_comb begin
    fill_line                 = line_buf_q;
    fill_line[LINE_WORDS-1]   = mem_rdata;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign word_we[w] = store_hit && hit_vec[w];
    assign fill_we[w] = refill_last && (victim_q == 1'(w));

    cache_way #(
      .NUM_SETS   (NUM_SETS),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_index  (cpu_index),
      .rd_offset (cpu_offset),
      .rd_valid  (way_valid[w]),
      .rd_tag    (way_tag[w]),
      .rd_word   (way_word[w]),
      .clear_all (do_flush),
      .word_we   (word_we[w]),
      .fill_we   (fill_we[w]),
      .wr_index  (wr_index),
      .wr_offset (cpu_offset),
      .wr_word   (merge_bytes(hit_word, cpu_wdata, cpu_byte_en)),
      .wr_tag    (addr_q[ADDR_W-1 -: TAG_W]),
      .wr_line   (fill_line)
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      refill_cnt_q <= '0;
      victim_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      lru_q        <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            lru_q <= '0;
          end else if (cpu_read_en) begin
            if (hit) begin
              hit_cnt_q        <= hit_cnt_q + 32'd1;
              lru_q[cpu_index] <= ~hit_way;
            end else begin
              miss_cnt_q   <= miss_cnt_q + 32'd1;
              victim_q     <= victim_sel;
              addr_q       <= cpu_addr[ADDR_W-1:BYTE_OFF_W];
              refill_cnt_q <= '0;
              state_q      <= StRefill;
            end
          end else if (cpu_write_en) begin
            if (hit) lru_q[cpu_index] <= ~hit_way;
            addr_q  <= cpu_addr[ADDR_W-1:BYTE_OFF_W];
            wdata_q <= cpu_wdata;
            be_q    <= cpu_byte_en;
            state_q <= StWrite;
          end
        end
        StRefill: begin
          if (mem_ready) begin
            refill_cnt_q <= refill_cnt_q + OFF_W'(1);
            if (refill_last) begin
              lru_q[refill_index] <= ~victim_q;
              state_q             <= StIdle;
            end
          end
        end
        StWrite: begin
          if (mem_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StRefill && mem_ready) line_buf_q[refill_cnt_q] <= mem_rdata;
  end

  always_comb begin
    cpu_rdata   = load_hit ? hit_word : '0;
    cpu_stall   = reset_n && (do_flush || load_miss || do_store || (state_q == StRefill) ||
                              ((state_q == StWrite) && !mem_ready));
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    unique case (state_q)
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:LINE_LSB], refill_cnt_q, 2'b00};
      end
      StWrite: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {addr_q, 2'b00};
        mem_wdata   = wdata_q;
        mem_byte_en = be_q;
      end
      default: ;
    endcase
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
